// File: rtl/btn_pkg.sv
// Shared types and timing defaults for the push-button conditioner.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } btn_state_e;

   localparam int CLK_HZ              = 10_000_000;
   localparam int DEF_DEBOUNCE_CYCLES = 512;
   localparam int DEF_REPEAT_DELAY    = CLK_HZ / 2;
   localparam int DEF_REPEAT_RATE     = CLK_HZ / 5;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM and registered pulses.
// Auto-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_channel
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release
);

   if (DEBOUNCE_CYCLES < 1 || REPEAT_RATE < 1 || REPEAT_DELAY < 0)
   begin : g_bad_param
      $error("btn_channel: illegal timing parameters");
   end

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic [1:0]    sync_q;
   logic          s;
   btn_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          press_all;

   assign s = sync_q[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= 2'b00;
         state_q   <= IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], btn_raw};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_all;
         release_q <= release_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            level_d = 1'b0;
            cnt_d   = '0;
            if (s) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = PRESSED;
                  press_d = 1'b1;
                  level_d = 1'b1;
               end else begin
                  state_d = DEB_PRESS;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         DEB_PRESS: begin
            if (!s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               cnt_d   = '0;
               press_d = 1'b1;
               level_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         PRESSED: begin
            level_d = 1'b1;
            if (!s) begin
               state_d = DEB_RELEASE;
               cnt_d   = CNT_ONE;
            end
         end
         DEB_RELEASE: begin
            if (s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d   = IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

`ifdef BTN_AUTO_REPEAT_EN
   localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_RATE);
   localparam int RW   = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DELAY_T = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RATE_T  = RW'(REPEAT_RATE);
   localparam logic [RW-1:0] RPT_ONE = RW'(1);

   logic [RW-1:0] rpt_q, rpt_d, rpt_tgt;
   logic          rep_q, rep_d;
   logic          rpt_pulse;

   always_ff @(posedge clk) begin
      if (reset) begin
         rpt_q <= '0;
         rep_q <= 1'b0;
      end else begin
         rpt_q <= rpt_d;
         rep_q <= rep_d;
      end
   end

   // rpt counts edges since the last press pulse; rep_q selects rate vs delay
   always_comb begin
      rpt_d     = rpt_q;
      rep_d     = rep_q;
      rpt_pulse = 1'b0;
      rpt_tgt   = rep_q ? RATE_T : DELAY_T;
      if (state_q == IDLE || state_q == DEB_PRESS) begin
         rpt_d = '0;
         rep_d = 1'b0;
      end else if (state_d == IDLE) begin
         rpt_d = '0;
         rep_d = 1'b0;
      end else if (rpt_q + RPT_ONE == rpt_tgt) begin
         rpt_pulse = 1'b1;
         rpt_d     = '0;
         rep_d     = 1'b1;
      end else if (rpt_q < rpt_tgt) begin
         rpt_d = rpt_q + RPT_ONE;
      end
   end

   assign press_all = press_d | rpt_pulse;
`else
   assign press_all = press_d;
`endif

   assign btn_level   = level_q;
   assign btn_press   = press_q;
   assign btn_release = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// Push-button input stage: NUM_BTN independent debounced channels.
// Optional auto-repeat: define BTN_AUTO_REPEAT_EN.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               any_press
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .btn_raw     (btn_raw[i]),
         .btn_level   (btn_level[i]),
         .btn_press   (btn_press[i]),
         .btn_release (btn_release[i])
      );
   end

   assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner (DEBOUNCE=4, DELAY=10, RATE=3).
module tb_btn_conditioner;

   localparam int NB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] btn_raw = '0;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          any_press;

   int edge_n = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int cyc;
      int ch;
      bit rel;
   } ev_t;

   ev_t sb[$];

   btn_conditioner #(
      .NUM_BTN         (NB),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_RATE     (3)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .any_press   (any_press)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic wait_edge(input int t);
      int guard;
      guard = 0;
      while (edge_n < t && guard < 500) begin
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic push_ev(input int t, input int ch, input bit rel);
      ev_t e;
      e.cyc = t;
      e.ch  = ch;
      e.rel = rel;
      sb.push_back(e);
   endtask

   // Matches every observed pulse against the expected-event queue.
   task automatic monitor();
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < NB; ch++) begin
            for (int k = 0; k < 2; k++) begin
               logic p;
               int   idx;
               p   = (k == 0) ? btn_press[ch] : btn_release[ch];
               idx = -1;
               if (p === 1'b1) begin
                  for (int i = 0; i < sb.size(); i++)
                     if (idx < 0 && sb[i].cyc == edge_n && sb[i].ch == ch
                         && sb[i].rel == (k == 1))
                        idx = i;
                  vectors++;
                  if (idx < 0) begin
                     miscompares++;
                     $display("FAIL unexpected_%s ch%0d edge %0d: got 1, need 0",
                              k ? "release" : "press", ch, edge_n);
                  end else begin
                     sb.delete(idx);
                  end
               end
            end
         end
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < edge_n) begin
               vectors++;
               miscompares++;
               $display("FAIL missed_%s ch%0d edge %0d: got 0, need 1",
                        sb[i].rel ? "release" : "press", sb[i].ch, sb[i].cyc);
               sb.delete(i);
            end
         end
         vectors++;
         if (any_press !== |btn_press) begin
            miscompares++;
            $display("FAIL any_press edge %0d: got %b, need %b",
                     edge_n, any_press, |btn_press);
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({btn_level, btn_press, btn_release, any_press} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, need 0",
                  {btn_level, btn_press, btn_release, any_press});
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
      vectors++;
      if (btn_level !== '0) begin
         miscompares++;
         $display("FAIL idle_level: got %b, need 0000", btn_level);
      end
   endtask

   task automatic test_clean_press();
      int t;
      t = edge_n + 7;
      btn_raw[0] = 1'b1;
      push_ev(t, 0, 1'b0);
      wait_edge(t - 1);
      vectors++;
      if (btn_level[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL clean_level_early: got %b, need 0", btn_level[0]);
      end
      wait_edge(t);
      vectors++;
      if (btn_level !== 4'b0001) begin
         miscompares++;
         $display("FAIL clean_level: got %b, need 0001", btn_level);
      end
      wait_edge(t + 1);
      btn_raw[0] = 1'b0;
      push_ev(t + 8, 0, 1'b1);
      wait_edge(t + 7);
      vectors++;
      if (btn_level[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL clean_hold_level: got %b, need 1", btn_level[0]);
      end
      wait_edge(t + 12);
   endtask

   task automatic test_glitch();
      int k;
      int t;
      k = edge_n;
      btn_raw[1] = 1'b1;
      wait_edge(k + 3);
      btn_raw[1] = 1'b0;
      wait_edge(k + 4);
      btn_raw[1] = 1'b1;
      t = k + 11;
      push_ev(t, 1, 1'b0);
      wait_edge(t);
      btn_raw[1] = 1'b0;
      wait_edge(t + 1);
      btn_raw[1] = 1'b1;
      wait_edge(t + 2);
      btn_raw[1] = 1'b0;
      push_ev(t + 9, 1, 1'b1);
      wait_edge(t + 8);
      vectors++;
      if (btn_level[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL glitch_hold_level: got %b, need 1", btn_level[1]);
      end
      wait_edge(t + 14);
   endtask

   task automatic test_release();
      int t;
      t = edge_n + 7;
      btn_raw[2] = 1'b1;
      push_ev(t, 2, 1'b0);
      wait_edge(t + 2);
      btn_raw[2] = 1'b0;
      push_ev(t + 9, 2, 1'b1);
      wait_edge(t + 8);
      vectors++;
      if (btn_level[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL release_level_before: got %b, need 1", btn_level[2]);
      end
      wait_edge(t + 9);
      vectors++;
      if (btn_level[2] !== 1'b0 || btn_release[2] !== 1'b1) begin
         miscompares++;
         $display("FAIL release_edge: level %b rel %b, need 0 1",
                  btn_level[2], btn_release[2]);
      end
      wait_edge(t + 14);
   endtask

   task automatic test_simultaneous();
      int t;
      t = edge_n + 7;
      btn_raw[3:2] = 2'b11;
      push_ev(t, 2, 1'b0);
      push_ev(t, 3, 1'b0);
      wait_edge(t);
      vectors++;
      if (btn_press !== 4'b1100 || any_press !== 1'b1) begin
         miscompares++;
         $display("FAIL simul_press: got %b/%b, need 1100/1", btn_press, any_press);
      end
      wait_edge(t + 1);
      vectors++;
      if (any_press !== 1'b0) begin
         miscompares++;
         $display("FAIL simul_any_width: got %b, need 0", any_press);
      end
      btn_raw[3:2] = 2'b00;
      push_ev(t + 8, 2, 1'b1);
      push_ev(t + 8, 3, 1'b1);
      wait_edge(t + 13);
   endtask

   task automatic test_auto_repeat();
      int t;
      t = edge_n + 7;
      btn_raw[0] = 1'b1;
      push_ev(t, 0, 1'b0);
`ifdef BTN_AUTO_REPEAT_EN
      for (int i = 0; i < 7; i++) push_ev(t + 10 + 3 * i, 0, 1'b0);
`endif
      wait_edge(t + 23);
      btn_raw[0] = 1'b0;
      push_ev(t + 30, 0, 1'b1);
      wait_edge(t + 29);
      vectors++;
      if (btn_level[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL repeat_hold_level: got %b, need 1", btn_level[0]);
      end
      wait_edge(t + 36);
   endtask

   task automatic test_reset_mid_hold();
      int t;
      int t2;
      t = edge_n + 7;
      btn_raw[1] = 1'b1;
      push_ev(t, 1, 1'b0);
      wait_edge(t + 2);
      reset = 1'b1;
      wait_edge(t + 3);
      vectors++;
      if ({btn_level, btn_press, btn_release, any_press} !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_hold: got %h, need 0",
                  {btn_level, btn_press, btn_release, any_press});
      end
      wait_edge(t + 4);
      reset = 1'b0;
      t2 = edge_n + 7;
      push_ev(t2, 1, 1'b0);
      wait_edge(t2 - 1);
      vectors++;
      if (btn_level[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL rearm_level_early: got %b, need 0", btn_level[1]);
      end
      wait_edge(t2);
      vectors++;
      if (btn_level[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL rearm_level: got %b, need 1", btn_level[1]);
      end
      btn_raw[1] = 1'b0;
      push_ev(t2 + 7, 1, 1'b1);
      wait_edge(t2 + 12);
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_clean_press();
      test_glitch();
      test_release();
      test_simultaneous();
      test_auto_repeat();
      test_reset_mid_hold();
      repeat (5) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending events, need 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
